// File: rtl/axil_csr_bank.sv
// AXI4-Lite control/status register bank: byte-strobed RW control registers, RO status
// registers with read strobes, and optional level/edge interrupt capture with W1C status.
module axil_csr_bank #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 12,
    parameter int CTRL       = 4,
    parameter int STAT       = 4,
    parameter int INTERRUPTS = 0,
    parameter logic [((INTERRUPTS > 0) ? INTERRUPTS : 1)-1:0] IRQ_EDGE = '0
) (
    input  logic                                         aclk,
    input  logic                                         areset,
    input  logic                                         awValid,
    output logic                                         awReady,
    input  logic [ADDR_W-1:0]                            awAddr,
    input  logic                                         wValid,
    output logic                                         wReady,
    input  logic [DATA_W-1:0]                            wData,
    input  logic [DATA_W/8-1:0]                          wStrb,
    output logic                                         bValid,
    input  logic                                         bReady,
    output logic [1:0]                                   bResp,
    input  logic                                         arValid,
    output logic                                         arReady,
    input  logic [ADDR_W-1:0]                            arAddr,
    output logic                                         rValid,
    input  logic                                         rReady,
    output logic [DATA_W-1:0]                            rData,
    output logic [1:0]                                   rResp,
    output logic [CTRL*DATA_W-1:0]                       ctrl,
    output logic [CTRL*DATA_W/8-1:0]                     ctrlWr,
    input  logic [((STAT > 0) ? STAT : 1)*DATA_W-1:0]    stat,
    output logic [((STAT > 0) ? STAT : 1)-1:0]           statRd,
    input  logic [((INTERRUPTS > 0) ? INTERRUPTS : 1)-1:0] interrupts,
    output logic                                         irq
);

    localparam int  STRB_W  = DATA_W / 8;
    localparam int  OFF_W   = $clog2(STRB_W);
    localparam int  STAT_N  = (STAT > 0) ? STAT : 1;
    localparam int  IRQ_W   = (INTERRUPTS > 0) ? INTERRUPTS : 1;
    localparam bit  HAS_IRQ = (INTERRUPTS > 0);

    localparam logic [ADDR_W-1:0] STAT_BASE    = ADDR_W'(CTRL);
    localparam logic [ADDR_W-1:0] IRQ_EN_IDX   = ADDR_W'(CTRL + STAT);
    localparam logic [ADDR_W-1:0] IRQ_STAT_IDX = ADDR_W'(CTRL + STAT + 1);
    localparam logic [ADDR_W-1:0] IRQ_PEND_IDX = ADDR_W'(CTRL + STAT + 2);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_idx;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] ctrl_r [CTRL];
    logic [IRQ_W-1:0]  irq_en, irq_stat, irq_prev;
    logic [IRQ_W-1:0]  irq_en_d, irq_stat_d, irq_event, irq_clr;

    logic              commit;
    logic [CTRL-1:0]   wr_ctrl;
    logic              wr_irq_en, wr_irq_stat;
    resp_t             wr_resp;

    logic [ADDR_W-1:0] ar_idx;
    logic [DATA_W-1:0] rd_data;
    resp_t             rd_resp;
    logic [STAT_N-1:0] rd_stat;

    assign awReady = !aw_held && !areset;
    assign wReady  = !w_held && !areset;
    assign arReady = (!rValid || rReady) && !areset;
    assign commit  = aw_held && w_held && (!bValid || bReady);
    assign ar_idx  = arAddr >> OFF_W;

    for (genvar i = 0; i < CTRL; i++) begin : g_ctrl_out
        assign ctrl[i*DATA_W +: DATA_W] = ctrl_r[i];
    end

    // NOTE: every always_comb output is given a default first, so no latch can be inferred.
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < STRB_W; b++) w_mask[b*8 +: 8] = {8{w_strb[b]}};
    end

    // Write-side decode of the held address.
    always_comb begin
        wr_resp     = RESP_DECERR;
        wr_ctrl     = '0;
        wr_irq_en   = 1'b0;
        wr_irq_stat = 1'b0;
        for (int i = 0; i < CTRL; i++) begin
            if (aw_idx == ADDR_W'(i)) begin
                wr_ctrl[i] = 1'b1;
                wr_resp    = RESP_OKAY;
            end
        end
        for (int i = 0; i < STAT; i++) begin
            if (aw_idx == STAT_BASE + ADDR_W'(i)) wr_resp = RESP_SLVERR;
        end
        if (HAS_IRQ) begin
            if (aw_idx == IRQ_EN_IDX) begin
                wr_irq_en = 1'b1;
                wr_resp   = RESP_OKAY;
            end
            if (aw_idx == IRQ_STAT_IDX) begin
                wr_irq_stat = 1'b1;
                wr_resp     = RESP_OKAY;
            end
            if (aw_idx == IRQ_PEND_IDX) wr_resp = RESP_SLVERR;
        end
    end

    // Read mux works on current register state, so a same-cycle commit is not visible.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_DECERR;
        rd_stat = '0;
        for (int i = 0; i < CTRL; i++) begin
            if (ar_idx == ADDR_W'(i)) begin
                rd_data = ctrl_r[i];
                rd_resp = RESP_OKAY;
            end
        end
        for (int i = 0; i < STAT; i++) begin
            if (ar_idx == STAT_BASE + ADDR_W'(i)) begin
                rd_data    = stat[i*DATA_W +: DATA_W];
                rd_resp    = RESP_OKAY;
                rd_stat[i] = 1'b1;
            end
        end
        if (HAS_IRQ) begin
            if (ar_idx == IRQ_EN_IDX) begin
                rd_data = DATA_W'(irq_en);
                rd_resp = RESP_OKAY;
            end
            if (ar_idx == IRQ_STAT_IDX) begin
                rd_data = DATA_W'(irq_stat);
                rd_resp = RESP_OKAY;
            end
            if (ar_idx == IRQ_PEND_IDX) begin
                rd_data = DATA_W'(irq_stat & irq_en);
                rd_resp = RESP_OKAY;
            end
        end
    end

    // A new capture takes priority over a write-1-to-clear of the same bit.
    always_comb begin
        irq_event  = (interrupts & ~irq_prev & IRQ_EDGE) | (interrupts & ~IRQ_EDGE);
        irq_clr    = (commit && wr_irq_stat) ? (w_data[IRQ_W-1:0] & w_mask[IRQ_W-1:0]) : '0;
        irq_en_d   = irq_en;
        irq_stat_d = '0;
        if (commit && wr_irq_en)
            irq_en_d = (irq_en & ~w_mask[IRQ_W-1:0]) | (w_data[IRQ_W-1:0] & w_mask[IRQ_W-1:0]);
        if (HAS_IRQ) irq_stat_d = (irq_stat & ~irq_clr) | (irq_event & irq_en);
        else         irq_en_d   = '0;
    end

    // NOTE: the write payload is only consumed while its hold flag is set, so it carries no reset.
    always_ff @(posedge aclk) begin
        if (awValid && awReady) aw_idx <= awAddr >> OFF_W;
        if (wValid && wReady) begin
            w_data <= wData;
            w_strb <= wStrb;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bValid   <= 1'b0;
            bResp    <= RESP_OKAY;
            rValid   <= 1'b0;
            rData    <= '0;
            rResp    <= RESP_OKAY;
            ctrlWr   <= '0;
            statRd   <= '0;
            irq_en   <= '0;
            irq_stat <= '0;
            irq_prev <= '0;
            irq      <= 1'b0;
            for (int i = 0; i < CTRL; i++) ctrl_r[i] <= '0;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bValid  <= 1'b1;
                bResp   <= wr_resp;
            end else begin
                if (awValid && awReady) aw_held <= 1'b1;
                if (wValid && wReady)   w_held  <= 1'b1;
                if (bReady)             bValid  <= 1'b0;
            end

            for (int i = 0; i < CTRL; i++) begin
                if (commit && wr_ctrl[i]) ctrl_r[i] <= (ctrl_r[i] & ~w_mask) | (w_data & w_mask);
                ctrlWr[i*STRB_W +: STRB_W] <= (commit && wr_ctrl[i]) ? w_strb : '0;
            end

            if (arValid && arReady) begin
                rValid <= 1'b1;
                rData  <= rd_data;
                rResp  <= rd_resp;
            end else if (rReady) begin
                rValid <= 1'b0;
            end
            statRd <= (arValid && arReady) ? rd_stat : '0;

            irq_prev <= interrupts;
            irq_en   <= irq_en_d;
            irq_stat <= irq_stat_d;
            irq      <= |irq_stat;
        end
    end

endmodule

// File: tb/tb_axil_csr_bank.sv
// Directed self-checking bench for axil_csr_bank: 32-bit bus, 4 ctrl, 4 stat,
// two interrupt lines (line 0 level, line 1 rising edge).
module tb_axil_csr_bank;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NC = 4;
    localparam int NS = 4;
    localparam int NI = 2;

    logic              aclk = 1'b0;
    logic              areset;
    logic              awValid, awReady;
    logic [AW-1:0]     awAddr;
    logic              wValid, wReady;
    logic [DW-1:0]     wData;
    logic [DW/8-1:0]   wStrb;
    logic              bValid, bReady;
    logic [1:0]        bResp;
    logic              arValid, arReady;
    logic [AW-1:0]     arAddr;
    logic              rValid, rReady;
    logic [DW-1:0]     rData;
    logic [1:0]        rResp;
    logic [NC*DW-1:0]  ctrl;
    logic [NC*DW/8-1:0] ctrlWr;
    logic [NS*DW-1:0]  stat;
    logic [NS-1:0]     statRd;
    logic [NI-1:0]     interrupts;
    logic              irq;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axil_csr_bank #(
        .DATA_W(DW), .ADDR_W(AW), .CTRL(NC), .STAT(NS),
        .INTERRUPTS(NI), .IRQ_EDGE(2'b10)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awValid(awValid), .awReady(awReady), .awAddr(awAddr),
        .wValid(wValid), .wReady(wReady), .wData(wData), .wStrb(wStrb),
        .bValid(bValid), .bReady(bReady), .bResp(bResp),
        .arValid(arValid), .arReady(arReady), .arAddr(arAddr),
        .rValid(rValid), .rReady(rReady), .rData(rData), .rResp(rResp),
        .ctrl(ctrl), .ctrlWr(ctrlWr), .stat(stat), .statRd(statRd),
        .interrupts(interrupts), .irq(irq)
    );

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int   n;
        logic hs_aw, hs_w;
        n = 0;
        awAddr = a; wData = d; wStrb = s;
        awValid = 1'b1; wValid = 1'b1; bReady = 1'b1;
        while ((awValid || wValid) && n < 20) begin
            hs_aw = awValid && awReady;
            hs_w  = wValid && wReady;
            tick; n++;
            if (hs_aw) awValid = 1'b0;
            if (hs_w)  wValid  = 1'b0;
        end
        while (!bValid && n < 20) begin tick; n++; end
        checks++;
        if (bValid !== 1'b1) begin
            errors++;
            $display("FAIL write_timeout addr=%h: bValid got %b want 1", a, bValid);
            resp = 2'bxx;
        end else begin
            resp = bResp;
        end
        tick;
        bReady = 1'b0; awValid = 1'b0; wValid = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
        int n;
        n = 0;
        arAddr = a; arValid = 1'b1; rReady = 1'b1;
        while (!arReady && n < 20) begin tick; n++; end
        tick;
        arValid = 1'b0;
        checks++;
        if (rValid !== 1'b1) begin
            errors++;
            $display("FAIL read_latency addr=%h: rValid got %b want 1", a, rValid);
            d = 'x; resp = 2'bxx;
        end else begin
            d = rData; resp = rResp;
        end
        tick;
        rReady = 1'b0;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        awValid = 0; wValid = 0; bReady = 0; arValid = 0; rReady = 0;
        awAddr = '0; wData = '0; wStrb = '0; arAddr = '0;
        stat = '0; interrupts = '0;
        tick; tick;
        checks++;
        if (awReady !== 1'b0 || arReady !== 1'b0) begin
            errors++; $display("FAIL reset_ready_low: got aw=%b ar=%b want 0 0", awReady, arReady);
        end
        areset = 1'b0;
        #1;
        checks++;
        if ({awReady, wReady, arReady} !== 3'b111) begin
            errors++; $display("FAIL reset_ready_high: got %b want 111", {awReady, wReady, arReady});
        end
        checks++;
        if ({bValid, rValid, irq} !== 3'b000 || statRd !== '0) begin
            errors++; $display("FAIL reset_outputs: got b=%b r=%b irq=%b statRd=%b want 0", bValid, rValid, irq, statRd);
        end
        checks++;
        if (ctrl !== '0 || ctrlWr !== '0) begin
            errors++; $display("FAIL reset_ctrl: got ctrl=%h ctrlWr=%h want 0", ctrl, ctrlWr);
        end
        tick;
    endtask

    task automatic test_strobe_write;
        awAddr = 12'h004; wData = 32'hA5A5_1234; wStrb = 4'b0101; bReady = 1'b0;
        awValid = 1'b1; wValid = 1'b1;
        tick;
        awValid = 1'b0; wValid = 1'b0;
        checks++;
        if (ctrl[63:32] !== 32'h0 || bValid !== 1'b0) begin
            errors++; $display("FAIL strobe_commit_cycle: got ctrl1=%h bValid=%b want 0 0", ctrl[63:32], bValid);
        end
        tick;
        checks++;
        if (ctrl[63:32] !== 32'h00A5_0034) begin
            errors++; $display("FAIL strobe_data: got %h want 00a50034", ctrl[63:32]);
        end
        checks++;
        if (ctrlWr !== 16'h0050) begin
            errors++; $display("FAIL strobe_ctrlwr: got %h want 0050", ctrlWr);
        end
        checks++;
        if (bValid !== 1'b1 || bResp !== 2'b00) begin
            errors++; $display("FAIL strobe_bresp: got v=%b resp=%b want 1 00", bValid, bResp);
        end
        tick;
        checks++;
        if (ctrlWr !== 16'h0 || bValid !== 1'b1) begin
            errors++; $display("FAIL strobe_pulse_once: got ctrlWr=%h bValid=%b want 0 1", ctrlWr, bValid);
        end
        bReady = 1'b1;
        tick;
        checks++;
        if (bValid !== 1'b0) begin
            errors++; $display("FAIL strobe_bdone: got %b want 0", bValid);
        end
        bReady = 1'b0;
    endtask

    task automatic test_w_before_aw;
        bReady = 1'b0;
        wData = 32'h1122_3344; wStrb = 4'hF; wValid = 1'b1;
        tick;
        wValid = 1'b0;
        checks++;
        if (wReady !== 1'b0 || awReady !== 1'b1) begin
            errors++; $display("FAIL early_w_ready: got w=%b aw=%b want 0 1", wReady, awReady);
        end
        tick;
        awAddr = 12'h008; awValid = 1'b1;
        tick;
        awValid = 1'b0;
        tick;
        checks++;
        if (bValid !== 1'b1 || ctrl[95:64] !== 32'h1122_3344) begin
            errors++; $display("FAIL early_w_commit: got bValid=%b ctrl2=%h want 1 11223344", bValid, ctrl[95:64]);
        end
        awAddr = 12'h00C; wData = 32'h0000_0055; awValid = 1'b1; wValid = 1'b1;
        tick;
        awValid = 1'b0; wValid = 1'b0;
        checks++;
        if (awReady !== 1'b0 || wReady !== 1'b0) begin
            errors++; $display("FAIL stall_ready: got aw=%b w=%b want 0 0", awReady, wReady);
        end
        tick; tick;
        checks++;
        if (bValid !== 1'b1 || ctrl[127:96] !== 32'h0 || ctrlWr !== 16'h0 || {awReady, wReady} !== 2'b00) begin
            errors++; $display("FAIL stall_no_commit: got bValid=%b ctrl3=%h ctrlWr=%h rdy=%b want 1 0 0 00",
                               bValid, ctrl[127:96], ctrlWr, {awReady, wReady});
        end
        bReady = 1'b1;
        tick;
        checks++;
        if (bValid !== 1'b1 || ctrl[127:96] !== 32'h0000_0055 || ctrlWr !== 16'hF000) begin
            errors++; $display("FAIL stall_release: got bValid=%b ctrl3=%h ctrlWr=%h want 1 00000055 f000",
                               bValid, ctrl[127:96], ctrlWr);
        end
        tick;
        checks++;
        if (bValid !== 1'b0 || ctrl[95:64] !== 32'h1122_3344) begin
            errors++; $display("FAIL stall_drain: got bValid=%b ctrl2=%h want 0 11223344", bValid, ctrl[95:64]);
        end
        bReady = 1'b0;
    endtask

    task automatic test_errors;
        logic [1:0]    resp;
        logic [DW-1:0] d;
        axi_write(12'h010, 32'hFFFF_FFFF, 4'hF, resp);
        checks++;
        if (resp !== 2'b10 || ctrl[31:0] !== 32'h0) begin
            errors++; $display("FAIL stat_write: got resp=%b ctrl0=%h want 10 0", resp, ctrl[31:0]);
        end
        axi_write(12'h028, 32'hFFFF_FFFF, 4'hF, resp);
        checks++;
        if (resp !== 2'b10) begin
            errors++; $display("FAIL pend_write: got %b want 10", resp);
        end
        axi_write(12'h0F0, 32'h1234_5678, 4'hF, resp);
        checks++;
        if (resp !== 2'b11) begin
            errors++; $display("FAIL unmapped_write: got %b want 11", resp);
        end
        axi_read(12'h0F0, d, resp);
        checks++;
        if (d !== 32'h0 || resp !== 2'b11) begin
            errors++; $display("FAIL unmapped_read: got %h/%b want 0/11", d, resp);
        end
        axi_read(12'h006, d, resp);
        checks++;
        if (d !== 32'h00A5_0034 || resp !== 2'b00) begin
            errors++; $display("FAIL offset_read: got %h/%b want 00a50034/00", d, resp);
        end
    endtask

    task automatic test_stat_read;
        logic [AW-1:0] addrs [3] = '{12'h010, 12'h014, 12'h004};
        logic [DW-1:0] exp_d [3] = '{32'h1000_0000, 32'h2000_0001, 32'h00A5_0034};
        logic [NS-1:0] exp_s [3] = '{4'b0001, 4'b0010, 4'b0000};
        stat = {32'h0, 32'hDEAD_BEEF, 32'h2000_0001, 32'h1000_0000};
        arAddr = 12'h018; arValid = 1'b1; rReady = 1'b1;
        tick;
        arValid = 1'b0;
        checks++;
        if (rValid !== 1'b1 || rData !== 32'hDEAD_BEEF || rResp !== 2'b00) begin
            errors++; $display("FAIL stat_read: got v=%b %h/%b want 1 deadbeef/00", rValid, rData, rResp);
        end
        checks++;
        if (statRd !== 4'b0100) begin
            errors++; $display("FAIL stat_rd_pulse: got %b want 0100", statRd);
        end
        tick;
        checks++;
        if (statRd !== 4'b0000 || rValid !== 1'b0) begin
            errors++; $display("FAIL stat_rd_once: got statRd=%b rValid=%b want 0000 0", statRd, rValid);
        end
        arValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            arAddr = addrs[k];
            checks++;
            if (arReady !== 1'b1) begin
                errors++; $display("FAIL b2b_arready[%0d]: got %b want 1", k, arReady);
            end
            tick;
            checks++;
            if (rValid !== 1'b1 || rData !== exp_d[k] || statRd !== exp_s[k]) begin
                errors++; $display("FAIL b2b_read[%0d]: got v=%b %h statRd=%b want 1 %h %b",
                                   k, rValid, rData, statRd, exp_d[k], exp_s[k]);
            end
        end
        arValid = 1'b0;
        tick;
        checks++;
        if (rValid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got %b want 0", rValid);
        end
        rReady = 1'b0;
    endtask

    task automatic test_irq;
        logic [1:0]    resp;
        logic [DW-1:0] d;
        axi_write(12'h020, 32'h0000_0003, 4'hF, resp);
        axi_read(12'h020, d, resp);
        checks++;
        if (d !== 32'h3 || resp !== 2'b00) begin
            errors++; $display("FAIL irq_en_read: got %h/%b want 3/00", d, resp);
        end
        axi_read(12'h024, d, resp);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL irq_idle: got stat=%h irq=%b want 0 0", d, irq);
        end
        interrupts = 2'b10;
        tick;
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_lag: got %b want 0", irq);
        end
        tick;
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_rise: got %b want 1", irq);
        end
        tick; tick; tick;
        axi_read(12'h024, d, resp);
        checks++;
        if (d !== 32'h2) begin
            errors++; $display("FAIL irq_edge_stat: got %h want 2", d);
        end
        axi_read(12'h028, d, resp);
        checks++;
        if (d !== 32'h2 || resp !== 2'b00) begin
            errors++; $display("FAIL irq_pend: got %h/%b want 2/00", d, resp);
        end
        interrupts = 2'b11;
        axi_write(12'h024, 32'h0000_0002, 4'hF, resp);
        axi_read(12'h024, d, resp);
        checks++;
        if (d !== 32'h1 || irq !== 1'b1) begin
            errors++; $display("FAIL irq_w1c: got stat=%h irq=%b want 1 1", d, irq);
        end
    endtask

    task automatic test_w1c_collision;
        logic [1:0]    resp;
        logic [DW-1:0] d;
        axi_write(12'h024, 32'h0000_0001, 4'hF, resp);
        axi_read(12'h024, d, resp);
        checks++;
        if (d !== 32'h1 || irq !== 1'b1) begin
            errors++; $display("FAIL w1c_set_wins: got stat=%h irq=%b want 1 1", d, irq);
        end
        interrupts = 2'b00;
        axi_write(12'h024, 32'h0000_0001, 4'hF, resp);
        axi_read(12'h024, d, resp);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL w1c_clear: got stat=%h irq=%b want 0 0", d, irq);
        end
    endtask

    task automatic test_reset_mid;
        awAddr = 12'h000; wData = 32'hFFFF_FFFF; wStrb = 4'hF; bReady = 1'b1;
        awValid = 1'b1; wValid = 1'b1;
        tick;
        awValid = 1'b0; wValid = 1'b0;
        areset = 1'b1;
        tick;
        areset = 1'b0;
        tick; tick; tick;
        checks++;
        if (bValid !== 1'b0 || ctrl !== '0 || {awReady, wReady} !== 2'b11) begin
            errors++; $display("FAIL reset_mid: got bValid=%b ctrl=%h rdy=%b want 0 0 11",
                               bValid, ctrl, {awReady, wReady});
        end
        bReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_strobe_write;
        test_w_before_aw;
        test_errors;
        test_stat_read;
        test_irq;
        test_w1c_collision;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_csr_bank.md
# axil_csr_bank

Parametrised AXI4-Lite control/status register bank, the next generation of the team's fixed 32-bit CSR block. It adds selectable data width, independent AW/W acceptance, error responses for unmapped or read-only writes, per-register byte write strobes and status read strobes, and per-line level/edge interrupt capture with write-1-to-clear status. It sits between the AXI-Lite interconnect and a peripheral core.

## Interface
- DATA_W, 32: register and bus data width; 32 or 64.
- ADDR_W, 12: AXI-Lite byte address width; must cover (CTRL+STAT+3) words.
- CTRL, 4: number of read/write control registers, 1..64.
- STAT, 4: number of read-only status registers, 0..64.
- INTERRUPTS, 0: interrupt lines, 0..DATA_W; 0 removes the interrupt registers and ties irq low.
- IRQ_EDGE, '0: INTERRUPTS-bit mask; 1 = rising-edge capture, 0 = level capture.
- aclk  in  1  clock for everything.
- areset  in  1  synchronous, active-high reset.
- awValid/awReady  in/out  1  write address handshake; awAddr  in  ADDR_W.
- wValid/wReady  in/out  1  write data handshake; wData  in  DATA_W; wStrb  in  DATA_W/8.
- bValid/bReady  out/in  1  write response handshake; bResp  out  2.
- arValid/arReady  in/out  1  read address handshake; arAddr  in  ADDR_W.
- rValid/rReady  out/in  1  read data handshake; rData  out  DATA_W; rResp  out  2.
- ctrl  out  CTRL*DATA_W  control register contents, register i at [i*DATA_W +: DATA_W].
- ctrlWr  out  CTRL*DATA_W/8  one-cycle byte-write pulses, register i at [i*DATA_W/8 +: DATA_W/8].
- stat  in  STAT*DATA_W  status inputs, same packing as ctrl.
- statRd  out  STAT  one-cycle pulse when status register i is read.
- interrupts  in  max(INTERRUPTS,1)  interrupt sources.
- irq  out  1  registered OR of IRQ_STAT.

## Operation
- Word index = addr >> log2(DATA_W/8). Low byte-offset bits are ignored.
- Register map:
  - 0..CTRL-1: ctrl (RW).
  - CTRL..CTRL+STAT-1: stat (RO).
  - Then, if INTERRUPTS>0: IRQ_EN (RW), IRQ_STAT (RW1C), IRQ_PEND (RO, IRQ_STAT & IRQ_EN).
  - Interrupt registers are INTERRUPTS bits wide; upper bits read 0.
- Write path:
  - AW and W are captured independently into one holding register each.
  - awReady = !awHeld; wReady = !wHeld.
  - Commit happens in the cycle where both are held and (!bValid || bReady). Commit clears both holds and loads the B slot.
  - Commit on ctrl i: bytes with wStrb set are updated; ctrlWr pulses the same bytes; bResp OKAY.
  - Commit on IRQ_EN: byte-masked write. IRQ_STAT: byte-masked write-1-clear.
  - Commit on stat or IRQ_PEND: no state change, bResp SLVERR (2'b10).
  - Unmapped index: bResp DECERR (2'b11).
- Read path:
  - arReady = !rValid || rReady.
  - AR handshake registers rData, rResp and rValid for the next cycle.
  - Unmapped index: rData 0, DECERR.
  - Reading stat i pulses statRd[i] in the same cycle rValid first rises.
- Interrupt capture:
  - event[g] = IRQ_EDGE[g] ? (interrupts[g] && !prev[g]) : interrupts[g].
  - IRQ_STAT[g] sets on event[g] && IRQ_EN[g].
  - W1C clears the bit, except that a set in the same cycle wins.
  - prev is registered every cycle.

## Timing
- Reset (areset high at an edge): all outputs, ctrl, IRQ_EN, IRQ_STAT, prev and holds go to 0; awReady, wReady and arReady go high in the first cycle after reset deasserts.
- Reset mid-transaction drops it silently; no B or R is issued.
- AW and W handshaken in cycle 0: commit in cycle 1. In cycle 2, ctrl shows new data, ctrlWr pulses and bValid goes high.
- W earlier than AW: commit in the cycle after the AW handshake.
- bValid held with bReady low: holds may fill, but no commit happens and awReady/wReady stay low once full.
- Read latency: 1 cycle from AR handshake to rValid. With rReady held high, one read per cycle is sustained.
- Read and commit to the same register in the same cycle: the read returns the pre-write value.
- irq lags IRQ_STAT by 1 cycle.

## Test plan
- Write ctrl 1, DATA_W=32, wData 0xA5A5_1234, wStrb 4'b0101, AW and W same cycle -> ctrl[1]=0x00A5_0034 in cycle 2, ctrlWr[7:4]=4'b0101 for one cycle, bResp 2'b00.
- W two cycles before AW, bReady low for 3 cycles -> single bValid held until bReady, no second commit, awReady/wReady stay low while holds are full.
- Write stat 0 -> bResp 2'b10, no change; read index 60 with CTRL=STAT=4 -> rData 0, rResp 2'b11.
- Read stat 2 with stat input 0xDEAD_BEEF -> rData 0xDEAD_BEEF one cycle after AR, statRd[2] pulses once; back-to-back ARs with rReady high -> one response per cycle.
- INTERRUPTS=2, IRQ_EDGE=2'b10, IRQ_EN=3: line 1 held high for 5 cycles -> IRQ_STAT=2'b10 once, irq high; W1C 0x2 with line 0 held high -> IRQ_STAT=2'b01.
- W1C IRQ_STAT bit 0 in the same cycle as a new level event on line 0 -> bit stays 1, irq stays high.
